aes_cp_sequencer: RTL

//  Bus-master sequencer for aes256_coprocessor. Accepts one 128-bit block request via valid/ready,

---
 rtl/aes_cp_sequencer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/aes_cp_sequencer.sv
// rtl/aes_cp_sequencer.sv - bus-master sequencer driving the aes256 coprocessor register port
// Purpose: accepts one 128-bit block request, programs the coprocessor (optional reset,
//   nonce and key reload, data push, run), waits for its interrupt, reads back four result
//   words and returns them as one response. A missing interrupt aborts with rsp_err=1.
// Ports:
//   clock, rst_n                      clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready/req_data      request handshake and block (word0 = [31:0])
//   req_load_key, key, nonce          key+nonce reload request and values, sampled at accept
//   rsp_valid/rsp_ready/rsp_data      response handshake and block (word0 = [31:0])
//   rsp_err                           response is a timeout abort, rsp_data = 0
//   cp_addr/cp_wdata/cp_we/cp_rdata   coprocessor register port (outputs registered)
//   cp_int                            coprocessor block-done interrupt
//   busy                              sequencer not idle
module aes_cp_sequencer #(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 11
) (
  input  logic         clock,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [127:0] req_data,
  input  logic         req_load_key,
  input  logic [255:0] key,
  input  logic [127:0] nonce,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_data,
  output logic         rsp_err,
  output logic [3:0]   cp_addr,
  output logic [31:0]  cp_wdata,
  output logic         cp_we,
  input  logic [31:0]  cp_rdata,
  input  logic         cp_int,
  output logic         busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_CP_RST, S_NONCE, S_KEY, S_PUSH, S_RUN, S_WAIT_INT, S_READ, S_RESP, S_ABORT
  } state_t;

  state_t           state, state_d;
  logic [2:0]       idx, idx_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             key_loaded, key_loaded_d;
  logic [127:0]     data_q, nonce_q, rdata_q;
  logic [255:0]     key_q;
  logic [3:0]       addr_d;
  logic [31:0]      wdata_d;
  logic             we_d;
  logic             accept;
  logic [127:0]     blk;

  // req_ready is held low while reset is asserted even though state is already IDLE.
  assign req_ready = rst_n && (state == S_IDLE);
  assign accept    = req_ready && req_valid;
  assign busy      = (state != S_IDLE);
  assign rsp_valid = (state == S_RESP) || (state == S_ABORT);
  assign rsp_err   = (state == S_ABORT);
  assign rsp_data  = (state == S_RESP) ? rdata_q : 128'h0;

  // PUSH can follow accept directly, so its first word must come from the live input.
  assign blk = accept ? req_data : data_q;

  always_comb begin
    state_d      = state;
    key_loaded_d = key_loaded;
    cnt_d        = '0;
    case (state)
      S_IDLE:     if (accept) state_d = (req_load_key || !key_loaded) ? S_CP_RST : S_PUSH;
      S_CP_RST:   if (idx == 3'd1) state_d = S_NONCE;
      S_NONCE:    if (idx == 3'd3) state_d = S_KEY;
      S_KEY: begin
        if (idx == 3'd7) begin
          state_d      = S_PUSH;
          key_loaded_d = 1'b1;
        end
      end
      S_PUSH:     if (idx == 3'd3) state_d = S_RUN;
      S_RUN:      state_d = S_WAIT_INT;
      S_WAIT_INT: begin
        // cnt holds the number of wait cycles already completed before this one.
        if (cp_int)                             state_d = S_READ;
        else if (cnt == CNT_W'(TIMEOUT - 1))    state_d = S_ABORT;
        else cnt_d = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
      end
      S_READ:     if (idx == 3'd3) state_d = S_RESP;
      S_RESP:     if (rsp_ready) state_d = S_IDLE;
      S_ABORT: begin
        key_loaded_d = 1'b0;
        if (rsp_ready) state_d = S_IDLE;
      end
      default:    state_d = S_IDLE;
    endcase

    idx_d = (state_d == state) ? idx + 3'd1 : 3'd0;

    // Register-port values are decoded from the next state so they line up with it.
    we_d    = 1'b0;
    addr_d  = 4'd0;
    wdata_d = 32'h0;
    case (state_d)
      S_CP_RST: begin
        we_d    = 1'b1;
        wdata_d = (idx_d == 3'd0) ? 32'h2 : 32'h0;
      end
      S_NONCE: begin
        we_d    = 1'b1;
        addr_d  = 4'd1 + {1'b0, idx_d};
        wdata_d = nonce_q[{idx_d[1:0], 5'd0} +: 32];
      end
      S_KEY: begin
        we_d    = 1'b1;
        addr_d  = 4'd5 + {1'b0, idx_d};
        wdata_d = key_q[{idx_d, 5'd0} +: 32];
      end
      S_PUSH: begin
        we_d    = 1'b1;
        addr_d  = 4'd13;
        wdata_d = blk[{idx_d[1:0], 5'd0} +: 32];
      end
      S_RUN: begin
        we_d    = 1'b1;
        wdata_d = 32'h1;
      end
      S_READ:  addr_d = 4'd14;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      idx        <= 3'd0;
      cnt        <= '0;
      key_loaded <= 1'b0;
      cp_addr    <= 4'd0;
      cp_wdata   <= 32'h0;
      cp_we      <= 1'b0;
      data_q     <= 128'h0;
      nonce_q    <= 128'h0;
      key_q      <= 256'h0;
      rdata_q    <= 128'h0;
    end else begin
      state      <= state_d;
      idx        <= idx_d;
      cnt        <= cnt_d;
      key_loaded <= key_loaded_d;
      cp_addr    <= addr_d;
      cp_wdata   <= wdata_d;
      cp_we      <= we_d;
      if (accept) begin
        data_q  <= req_data;
        nonce_q <= nonce;
        key_q   <= key;
      end
      // The coprocessor pops one result word per clock while addr 14 is presented.
      if (state == S_READ) rdata_q[{idx[1:0], 5'd0} +: 32] <= cp_rdata;
    end
  end

endmodule
